// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port (word address, byte write
// enables, one-cycle read latency) between the instruction-fetch requester
// and the load/store data requester.
//
// Data has priority. A saturating starvation counter forces a fetch grant
// after STARVE_MAX consecutive data wins against a waiting fetch.
// STARVE_MAX = 0 makes fetch always win.
// Each granted read is tagged with its owner, and the returned word is
// steered to the matching requester with a valid strobe.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   if_req/if_addr                fetch request and word address
//   if_gnt                        fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata            fetch read response, 1 cycle after grant
//   d_req/d_re/d_we/d_addr/d_wdata  data request and attributes
//   d_gnt                         data accepted this cycle (combinational)
//   d_rvalid/d_rdata              data read response, 1 cycle after grant
//   mem_re/mem_we/mem_addr/mem_wdata  RAM command
//   mem_rdata                     RAM read data, valid the cycle after mem_re
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] CNT_SAT    = 4'hF;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       pend_if_q, pend_if_d;
  logic       pend_d_q, pend_d_d;
  logic       force_if;

  always_comb begin
    force_if = if_req && (starve_cnt_q >= STARVE_LIM);

    // Grants are gated with reset_n so nothing is accepted while reset is held.
    d_gnt  = reset_n && d_req && !force_if;
    if_gnt = reset_n && if_req && !d_gnt;

    mem_addr  = d_gnt ? d_addr : if_addr;
    mem_wdata = d_wdata;
    mem_re    = d_gnt ? d_re : if_gnt;
    mem_we    = d_gnt ? d_we : '0;

    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != CNT_SAT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Writes and null data requests finish in their grant cycle,
    // so only data reads leave a response pending.
    pend_if_d = if_gnt;
    pend_d_d  = d_gnt && d_re;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
      pend_if_q    <= 1'b0;
      pend_d_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pend_if_q    <= pend_if_d;
      pend_d_q     <= pend_d_d;
    end
  end

  assign if_rvalid = pend_if_q;
  assign d_rvalid  = pend_d_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (STARVE_MAX = 4 and 0) share the
// stimulus; each drives its own RAM model. A reference model tracks
// consecutive data wins, expected read owners and its own copy of memory.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_re = 1'b0;
  logic [3:0]  d_we = '0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        mem_re [2];
  logic [3:0]  mem_we [2];
  logic [29:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.STARVE_MAX(0)) u_dut_nostarve (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string nm(input string s, input int k);
    return $sformatf("%s[%0d]", s, k);
  endfunction

  function automatic logic [31:0] init_word(input int unsigned a);
    if (a == 32'h10) return 32'hDEADBEEF;
    if (a == 32'h3)  return 32'h12345678;
    return 32'hA5000000 | a;
  endfunction

  // RAM attached to each DUT: registered read, byte-enabled write.
  logic [31:0] ram [2][256];
  logic [31:0] ref_mem [2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_re[k]) mem_rdata[k] <= ram[k][mem_addr[k][7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[k][b]) ram[k][mem_addr[k][7:0]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
    end
  end

  // Reference model state
  int unsigned sm [2] = '{4, 0};
  int unsigned wins [2] = '{0, 0};
  logic        ev_if [2] = '{1'b0, 1'b0};
  logic        ev_d [2] = '{1'b0, 1'b0};
  logic [31:0] ev_data [2];
  int unsigned nx_wins [2] = '{0, 0};
  logic        nx_if [2] = '{1'b0, 1'b0};
  logic        nx_d [2] = '{1'b0, 1'b0};
  logic [31:0] nx_data [2];

  // Every-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic e_ig, e_dg, frc;
    logic [29:0] a;
    for (int k = 0; k < 2; k++) begin
      frc  = if_req && (wins[k] >= sm[k]);
      e_dg = reset_n && d_req && !frc;
      e_ig = reset_n && if_req && !e_dg;
      a    = e_dg ? d_addr : if_addr;
      chk(nm("d_gnt", k), 32'(d_gnt[k]), 32'(e_dg));
      chk(nm("if_gnt", k), 32'(if_gnt[k]), 32'(e_ig));
      chk(nm("mem_re", k), 32'(mem_re[k]), 32'(e_dg ? d_re : e_ig));
      chk(nm("mem_we", k), 32'(mem_we[k]), 32'(e_dg ? d_we : 4'h0));
      chk(nm("mem_addr", k), 32'(mem_addr[k]), 32'(a));
      if (!e_ig) chk(nm("mem_wdata", k), mem_wdata[k], d_wdata);
      chk(nm("if_rvalid", k), 32'(if_rvalid[k]), 32'(ev_if[k]));
      chk(nm("d_rvalid", k), 32'(d_rvalid[k]), 32'(ev_d[k]));
      if (ev_if[k]) chk(nm("if_rdata", k), if_rdata[k], ev_data[k]);
      if (ev_d[k])  chk(nm("d_rdata", k), d_rdata[k], ev_data[k]);

      nx_if[k]   = e_ig;
      nx_d[k]    = e_dg && d_re;
      nx_data[k] = ref_mem[k][a[7:0]];
      if (e_dg)
        for (int b = 0; b < 4; b++)
          if (d_we[b]) ref_mem[k][a[7:0]][8*b +: 8] = d_wdata[8*b +: 8];
      if (e_ig || !if_req)      nx_wins[k] = 0;
      else if (e_dg)            nx_wins[k] = (wins[k] < 15) ? wins[k] + 1 : 15;
      else                      nx_wins[k] = wins[k];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        wins[k] = 0; ev_if[k] = 1'b0; ev_d[k] = 1'b0;
      end else begin
        wins[k] = nx_wins[k]; ev_if[k] = nx_if[k]; ev_d[k] = nx_d[k]; ev_data[k] = nx_data[k];
      end
    end
  end

  // 1 = fetch granted, 0 = data granted, for STARVE_MAX = 4 under full contention
  bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int unsigned i = 0; i < 256; i++) begin
        ram[k][i] <= init_word(i);
        ref_mem[k][i] = init_word(i);
      end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_rvalid", 32'(if_rvalid[0]), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid[0]), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Fetch only
    if_req = 1'b1; if_addr = 30'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit_fetch_gnt", 32'(if_gnt[0]), 32'd1);
      chk("lit_fetch_mem_re", 32'(mem_re[0]), 32'd1);
      chk("lit_fetch_d_rvalid", 32'(d_rvalid[0]), 32'd0);
      if (c > 0) begin
        chk("lit_fetch_rvalid", 32'(if_rvalid[0]), 32'd1);
        chk("lit_fetch_rdata", if_rdata[0], 32'hDEADBEEF);
      end
      next_cycle();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("lit_fetch_rvalid_last", 32'(if_rvalid[0]), 32'd1);
    chk("lit_fetch_rdata_last", if_rdata[0], 32'hDEADBEEF);
    next_cycle();

    // Data write
    d_req = 1'b1; d_we = 4'b0110; d_addr = 30'h3; d_wdata = 32'h00ABCD00;
    @(negedge clk);
    chk("lit_wr_gnt", 32'(d_gnt[0]), 32'd1);
    chk("lit_wr_mem_we", 32'(mem_we[0]), 32'h6);
    chk("lit_wr_mem_addr", 32'(mem_addr[0]), 32'h3);
    next_cycle();
    d_req = 1'b0; d_we = 4'h0;
    @(negedge clk);
    chk("lit_wr_no_rvalid", 32'(d_rvalid[0]), 32'd0);
    next_cycle();

    // Read back word 3
    d_req = 1'b1; d_re = 1'b1; d_addr = 30'h3;
    @(negedge clk);
    chk("lit_rd_gnt", 32'(d_gnt[0]), 32'd1);
    next_cycle();
    d_req = 1'b0; d_re = 1'b0;
    @(negedge clk);
    chk("lit_rd_rvalid", 32'(d_rvalid[0]), 32'd1);
    chk("lit_rd_rdata", d_rdata[0], 32'h12ABCD78);
    chk("lit_rd_if_rvalid", 32'(if_rvalid[0]), 32'd0);
    next_cycle();

    // Contention: fetch word 0x10, data read word 5
    if_req = 1'b1; if_addr = 30'h10; d_req = 1'b1; d_re = 1'b1; d_addr = 30'h5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("lit_cont_if_gnt_%0d", c), 32'(if_gnt[0]), 32'(exp_seq[c]));
      chk($sformatf("lit_cont_d_gnt_%0d", c), 32'(d_gnt[0]), 32'(!exp_seq[c]));
      chk($sformatf("lit_ns_if_gnt_%0d", c), 32'(if_gnt[1]), 32'd1);
      chk($sformatf("lit_ns_d_gnt_%0d", c), 32'(d_gnt[1]), 32'd0);
      if (c > 0) begin
        chk($sformatf("lit_cont_if_rv_%0d", c), 32'(if_rvalid[0]), 32'(exp_seq[c-1]));
        chk($sformatf("lit_cont_d_rv_%0d", c), 32'(d_rvalid[0]), 32'(!exp_seq[c-1]));
        chk($sformatf("lit_cont_rdata_%0d", c), if_rdata[0],
            exp_seq[c-1] ? 32'hDEADBEEF : 32'hA5000005);
      end
      next_cycle();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("lit_ns_d_gnt_after_drop", 32'(d_gnt[1]), 32'd1);
    chk("lit_cont_d_gnt_after_drop", 32'(d_gnt[0]), 32'd1);
    chk("lit_cont_if_rv_last", 32'(if_rvalid[0]), 32'd1);
    next_cycle();
    d_req = 1'b0; d_re = 1'b0;
    next_cycle();

    // Reset in the cycle after a fetch grant
    if_req = 1'b1; if_addr = 30'h10;
    @(negedge clk);
    chk("lit_pre_rst_if_gnt", 32'(if_gnt[0]), 32'd1);
    next_cycle();
    reset_n = 1'b0; d_req = 1'b1; d_re = 1'b1; d_addr = 30'h5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lit_rst_if_rvalid", 32'(if_rvalid[0]), 32'd0);
      chk("lit_rst_if_gnt", 32'(if_gnt[0]), 32'd0);
      chk("lit_rst_d_gnt", 32'(d_gnt[0]), 32'd0);
      chk("lit_rst_mem_re", 32'(mem_re[0]), 32'd0);
      next_cycle();
    end
    reset_n = 1'b1;
    // Starvation count must restart from zero after reset.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("lit_post_rst_if_gnt_%0d", c), 32'(if_gnt[0]), 32'(exp_seq[c]));
      chk($sformatf("lit_post_rst_d_gnt_%0d", c), 32'(d_gnt[0]), 32'(!exp_seq[c]));
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0; d_re = 1'b0;
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single synchronous memory port (word address, byte write enables, one-cycle read latency) between the instruction-fetch requester and the load/store (data) requester of the core. Data has priority, and a bounded starvation counter guarantees fetch progress. The block tracks which requester owns each in-flight read and routes the returned word back with a valid strobe. It sits between the fetch/mem stages and the RAM, upstream of the byte-lane formatting logic.

## Interface

Parameters:
- STARVE_MAX, default 4: maximum number of consecutive cycles in which data wins while fetch is requesting; legal range 0..15. A value of 0 means fetch always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  30  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid; one cycle after if_gnt
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; held with its attributes stable until d_gnt
- d_re  in  1  data read; mutually exclusive with d_we != 0
- d_we  in  4  data byte write enables
- d_addr  in  30  data word address
- d_wdata  in  32  data write word, already lane-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid; one cycle after a granted read
- d_rdata  out  32  data read data
- mem_re  out  1  RAM read enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  30  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re

## Operation

- **State.** The block holds the following registers:
  - starve_cnt, 4 bits;
  - pend_if, 1 bit;
  - pend_d, 1 bit.
- **Grant rule**, evaluated each cycle:
  - force_if = if_req && starve_cnt >= STARVE_MAX.
  - d_gnt = d_req && !force_if.
  - if_gnt = if_req && !d_gnt.
  - At most one grant is high in any cycle.
- **Memory drive, data granted:** mem_re = d_re, mem_we = d_we, mem_addr = d_addr, mem_wdata = d_wdata.
- **Memory drive, fetch granted:** mem_re = 1, mem_we = 0, mem_addr = if_addr.
- **Memory drive, no grant:** mem_re = 0, mem_we = 0, mem_addr = if_addr, mem_wdata = d_wdata.
- **Starvation counter update:**
  - if_gnt, or !if_req: starve_cnt <= 0.
  - d_gnt && if_req: starve_cnt <= starve_cnt + 1, saturating at 15.
- **Pending-read update:** pend_if <= if_gnt; pend_d <= d_gnt && d_re.
- **Read response:**
  - if_rvalid = pend_if and d_rvalid = pend_d; at most one is high.
  - if_rdata = d_rdata = mem_rdata. Consumers qualify the data with rvalid only.
- **Data writes and null requests:** a granted data write, or a data request with d_re = 0 and d_we = 0, completes in its grant cycle. It produces no rvalid.
- **Illegal request:** d_re = 1 together with d_we != 0 is illegal. In that case the block drives mem_re = 1 and mem_we = d_we unmodified, and does not check.

## Timing

- Reset values, with reset_n low or after reset:
  - starve_cnt = 0, pend_if = 0, pend_d = 0.
  - if_rvalid = 0, d_rvalid = 0.
  - While reset_n is low, if_gnt, d_gnt, mem_re and mem_we are forced to 0.
- Grant latency: 0 cycles (combinational from req). Read latency: rvalid exactly 1 cycle after the grant edge.
- Throughput: one access per cycle. Back-to-back grants to either side are allowed, and responses pipeline without bubbles.
- Simultaneous requests: data wins unless force_if. After STARVE_MAX consecutive data wins against a waiting fetch, the next cycle grants fetch.
- Reset mid-read: asserting reset_n low clears the pending bit immediately. The response is dropped and the requester must re-issue.
- A requester that deasserts req without a grant is not an error. No state is kept for ungranted requests.

## Test plan

- **Fetch only:** if_req = 1, if_addr = 0x10 for 3 cycles, RAM holding 0xDEADBEEF at word 0x10.
  - Required: if_gnt = 1 on every cycle, mem_re = 1, if_rvalid = 1 one cycle later with if_rdata = 0xDEADBEEF.
  - Required: d_rvalid stays 0.
- **Contention, STARVE_MAX = 4:** if_req and d_req (read) held high for 10 cycles.
  - Required grant sequence: d, d, d, d, if, d, d, d, d, if.
  - Required: each rvalid goes to the matching requester on the following cycle.
- **Data write:** d_req = 1, d_we = 4'b0110, d_addr = 0x3, d_wdata = 0x00ABCD00.
  - Required: mem_we = 4'b0110 and mem_addr = 0x3 in the grant cycle; d_rvalid = 0 next cycle.
  - Required: a later read of word 0x3 shows bytes 1 and 2 updated.
- **STARVE_MAX = 0:** both requesters active.
  - Required: fetch granted every cycle and data never granted until if_req drops.
  - Required: data granted in the first cycle with if_req = 0.
- **Reset:** assert reset_n low in the cycle after an if_gnt.
  - Required: if_rvalid = 0, starve_cnt = 0, and no grants while low.
  - Required: normal arbitration resumes the first cycle after release.
